// File: rtl/coo_aggregation_engine.sv
// coo_aggregation_engine: GCN aggregation over a COO edge list into saturating per-node accumulator rows
// Ports: clk/reset (async, active-low); start, num_edges (clamped to MAX_EDGES);
//   coo_addr -> coo_src/coo_dst (1-cycle read latency, 1-based node ids);
//   fm_rd_en/fm_rd_row -> fm_row (1-cycle read latency, 0-based rows);
//   rd_en/rd_row -> rd_data (registered host readout); busy, done (level), sat_flag (sticky).
// Optional: define COO_SYMMETRIC_EN to also accumulate each non-self edge in the reverse direction.
module coo_aggregation_engine #(
  parameter int NODES = 6,
  parameter int FEAT_COLS = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH = 20,
  parameter int MAX_EDGES = 6,
  localparam int NW = $clog2(NODES + 1),
  localparam int EW = $clog2(MAX_EDGES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [EW-1:0]                  num_edges,
  output logic [EW-1:0]                  coo_addr,
  input  logic [NW-1:0]                  coo_src,
  input  logic [NW-1:0]                  coo_dst,
  output logic                           fm_rd_en,
  output logic [NW-1:0]                  fm_rd_row,
  input  logic [FEAT_COLS*DATA_WIDTH-1:0] fm_row,
  input  logic                           rd_en,
  input  logic [NW-1:0]                  rd_row,
  output logic [FEAT_COLS*ACC_WIDTH-1:0] rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           sat_flag
);
  typedef enum logic [2:0] {IDLE, CLEAR, ADDR, FEAT, ACC, RFEAT, RACC, DONE} state_t;
  localparam logic [NW-1:0] ONE = NW'(1);
  localparam logic [NW-1:0] NODE_MAX = NW'(NODES);
  localparam logic [NW-1:0] LAST_ROW = NW'(NODES - 1);
  localparam logic [EW-1:0] EDGE_MAX = EW'(MAX_EDGES);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  state_t state_q, state_d, after_edge;
  logic [EW-1:0] e_q, e_d, lim_q, lim_d, e_inc;
  logic [NW-1:0] clr_q, clr_d, src_q, src_d, dst_q, dst_d, acc_row;
  logic done_q, done_d, sat_q, sat_d, busy_q, busy_d;
  logic edge_ok, acc_we;
  logic [FEAT_COLS*ACC_WIDTH-1:0] rd_data_q, rd_data_d;
  logic signed [ACC_WIDTH-1:0] acc_q [NODES][FEAT_COLS];
  logic signed [ACC_WIDTH-1:0] acc_new [FEAT_COLS];
  logic signed [ACC_WIDTH:0] sum [FEAT_COLS];
  logic [FEAT_COLS-1:0] ovf;
  assign edge_ok = coo_src != '0 && coo_src <= NODE_MAX && coo_dst != '0 && coo_dst <= NODE_MAX;
  assign e_inc = e_q + EW'(1);
  assign after_edge = e_inc == lim_q ? DONE : ADDR;
  // Forward pass accumulates into dst, reverse pass into src.
  assign acc_row = state_q == RACC ? src_q - ONE : dst_q - ONE;
  assign acc_we = state_q == ACC || state_q == RACC;
  assign coo_addr = e_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sat_flag = sat_q;
  assign rd_data = rd_data_q;
  // One extra guard bit per column; a mismatch of the top two bits means overflow.
  always_comb begin
    for (int c = 0; c < FEAT_COLS; c++) begin
      sum[c] = {acc_q[acc_row][c][ACC_WIDTH-1], acc_q[acc_row][c]}
             + (ACC_WIDTH+1)'($signed(fm_row[c*DATA_WIDTH +: DATA_WIDTH]));
      ovf[c] = sum[c][ACC_WIDTH] ^ sum[c][ACC_WIDTH-1];
      acc_new[c] = ovf[c] ? (sum[c][ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[c][ACC_WIDTH-1:0];
    end
  end
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      if (rd_row < NODE_MAX)
        for (int c = 0; c < FEAT_COLS; c++) rd_data_d[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[rd_row][c];
    end
  end
  always_comb begin
    state_d = state_q;
    e_d = e_q;
    lim_d = lim_q;
    clr_d = clr_q;
    src_d = src_q;
    dst_d = dst_q;
    done_d = done_q;
    sat_d = sat_q | (acc_we && |ovf);
    fm_rd_en = 1'b0;
    fm_rd_row = '0;
    case (state_q)
      IDLE, DONE: begin
        // done trails entry into DONE by one cycle and drops on an accepted restart.
        done_d = state_q == DONE;
        if (start) begin
          state_d = CLEAR;
          e_d = '0;
          clr_d = '0;
          sat_d = 1'b0;
          done_d = 1'b0;
          lim_d = num_edges > EDGE_MAX ? EDGE_MAX : num_edges;
        end
      end
      CLEAR: begin
        clr_d = clr_q + ONE;
        if (clr_q == LAST_ROW) state_d = lim_q == '0 ? DONE : ADDR;
      end
      ADDR: state_d = FEAT;
      FEAT: begin
        src_d = coo_src;
        dst_d = coo_dst;
        if (edge_ok) begin
          fm_rd_en = 1'b1;
          fm_rd_row = coo_src - ONE;
          state_d = ACC;
        end else begin
          e_d = e_inc;
          state_d = after_edge;
        end
      end
`ifdef COO_SYMMETRIC_EN
      ACC: begin
        if (src_q != dst_q) state_d = RFEAT;
        else begin
          e_d = e_inc;
          state_d = after_edge;
        end
      end
      RFEAT: begin
        fm_rd_en = 1'b1;
        fm_rd_row = dst_q - ONE;
        state_d = RACC;
      end
      RACC: begin
        e_d = e_inc;
        state_d = after_edge;
      end
`else
      ACC: begin
        e_d = e_inc;
        state_d = after_edge;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {CLEAR, ADDR, FEAT, ACC, RFEAT, RACC};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      e_q <= '0;
      lim_q <= '0;
      clr_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      done_q <= 1'b0;
      sat_q <= 1'b0;
      busy_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      e_q <= e_d;
      lim_q <= lim_d;
      clr_q <= clr_d;
      src_q <= src_d;
      dst_q <= dst_d;
      done_q <= done_d;
      sat_q <= sat_d;
      busy_q <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end
  // Accumulator storage is deliberately not reset; CLEAR zeroes it at every start.
  always_ff @(posedge clk) begin
    for (int c = 0; c < FEAT_COLS; c++)
      if (state_q == CLEAR) acc_q[clr_q][c] <= '0;
      else if (acc_we) acc_q[acc_row][c] <= acc_new[c];
  end
endmodule

// File: tb/tb_coo_aggregation_engine.sv
// tb_coo_aggregation_engine: directed table-driven bench for coo_aggregation_engine
module tb_coo_aggregation_engine;
  localparam int NW = 3, EW = 3;
`ifdef COO_SYMMETRIC_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif
  typedef struct {
    int n;
    logic [7:0][3:0] s;
    logic [7:0][3:0] d;
    logic [5:0][7:0] k;
    int cyc;
    int rds;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, start2, rd_en;
  logic [EW-1:0] num_edges;
  logic [NW-1:0] rd_row;
  logic [EW-1:0] coo_addr1, coo_addr2;
  logic [NW-1:0] src_r1, dst_r1, src_r2, dst_r2, fm_idx1, fm_idx2;
  logic fm_en1, fm_en2, busy1, busy2, done1, done2, sat1, sat2;
  logic [47:0] fm_r1, fm_r2;
  logic [59:0] rd_data1;
  logic [50:0] rd_data2;
  logic [NW-1:0] msrc [8];
  logic [NW-1:0] mdst [8];
  logic [47:0] fm1 [8];
  logic [47:0] fm2 [8];
  vec_t v [6];
  int ntest = 0, nfail = 0;
  coo_aggregation_engine dut1 (
    .clk(clk), .reset(reset), .start(start), .num_edges(num_edges), .coo_addr(coo_addr1),
    .coo_src(src_r1), .coo_dst(dst_r1), .fm_rd_en(fm_en1), .fm_rd_row(fm_idx1), .fm_row(fm_r1),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data1), .busy(busy1), .done(done1), .sat_flag(sat1));
  coo_aggregation_engine #(.ACC_WIDTH(17)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .num_edges(num_edges), .coo_addr(coo_addr2),
    .coo_src(src_r2), .coo_dst(dst_r2), .fm_rd_en(fm_en2), .fm_rd_row(fm_idx2), .fm_row(fm_r2),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data2), .busy(busy2), .done(done2), .sat_flag(sat2));
  // Memory models: one-cycle read latency; an unstrobed FM read returns all-ones junk.
  always @(posedge clk) begin
    src_r1 <= msrc[coo_addr1];
    dst_r1 <= mdst[coo_addr1];
    src_r2 <= msrc[coo_addr2];
    dst_r2 <= mdst[coo_addr2];
    fm_r1 <= fm_en1 ? fm1[fm_idx1] : '1;
    fm_r2 <= fm_en2 ? fm2[fm_idx2] : '1;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [59:0] exp_row(input int k);
    return {20'(100 * k), 20'(10 * k), 20'(k)};
  endfunction
  task automatic load(input int i);
    for (int j = 0; j < 8; j++) begin
      msrc[j] = NW'(v[i].s[j]);
      mdst[j] = NW'(v[i].d[j]);
    end
    num_edges = EW'(v[i].n);
  endtask
  task automatic run_vec(input int i, input bit poke);
    int cnt, rds;
    load(i);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    rds = 0;
    while (!done1 && cnt < 200) begin
      @(posedge clk);
      #1 cnt++;
      if (fm_en1) rds++;
      start = poke && cnt == 3;
    end
    start = 1'b0;
    chk($sformatf("v%0d cycles", i), 64'(cnt), 64'(v[i].cyc));
    chk($sformatf("v%0d fm reads", i), 64'(rds), 64'(v[i].rds));
    chk($sformatf("v%0d sat_flag", i), 64'(sat1), 64'(0));
    chk($sformatf("v%0d busy", i), 64'(busy1), 64'(0));
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      rd_en = 1'b1;
      rd_row = NW'(r);
      @(posedge clk);
      #1 chk($sformatf("v%0d row%0d", i, r), 64'(rd_data1), 64'(exp_row(int'(v[i].k[r]))));
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  task automatic run2(input string nm, input int n, input int cyc, input logic [50:0] exp1, input bit exps);
    int cnt;
    num_edges = EW'(n);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 200) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk({nm, " cycles"}, 64'(cnt), 64'(cyc));
    chk({nm, " sat_flag"}, 64'(sat2), 64'(exps));
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      rd_en = 1'b1;
      rd_row = NW'(r);
      @(posedge clk);
      #1 chk($sformatf("%s row%0d", nm, r), 64'(rd_data2), r == 1 ? 64'(exp1) : 64'(0));
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  initial begin
    int cnt;
    reset = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    rd_en = 1'b0;
    rd_row = '0;
    num_edges = '0;
    for (int r = 0; r < 8; r++) begin
      fm1[r] = {16'(100 * (r + 1)), 16'(10 * (r + 1)), 16'(r + 1)};
      fm2[r] = '0;
    end
    v[0] = '{2, 32'h31, 32'h22, SYM ? 48'h020402 : 48'h000400, SYM ? 17 : 13, SYM ? 4 : 2};
    v[1] = '{1, 32'h4, 32'h4, 48'h04000000, 10, 1};
    v[2] = '{3, 32'h270, 32'h113, SYM ? 48'h0102 : 48'h0002, SYM ? 16 : 14, SYM ? 2 : 1};
    v[3] = '{0, 32'h0, 32'h0, 48'h0, 7, 0};
    v[4] = '{7, 32'h02111111, 32'h02111111, 48'h06, 25, 6};
    v[5] = '{4, 32'h5632, 32'h6533, SYM ? 48'h0A0C00050300 : 48'h050600050000, SYM ? 25 : 19, SYM ? 7 : 4};
    #12;
    chk("reset outputs", 64'({busy1, done1, sat1, fm_en1, coo_addr1, rd_data1}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(i, 1'b0);
    load(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (!fm_en1 && cnt < 50) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("reach first fm read", 64'(fm_en1), 64'(1));
    @(posedge clk);
    #1 chk("busy in ACC", 64'(busy1), 64'(1));
    reset = 1'b0;
    #1 chk("mid-op reset outputs", 64'({busy1, done1, sat1, fm_en1, coo_addr1, fm_idx1, rd_data1}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    run_vec(0, 1'b1);
    for (int r = 6; r < 8; r++) begin
      @(negedge clk);
      rd_en = 1'b1;
      rd_row = NW'(r);
      @(posedge clk);
      #1 chk($sformatf("out-of-range row%0d", r), 64'(rd_data1), 64'(0));
    end
    @(negedge clk);
    rd_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      msrc[j] = j < 3 ? NW'(1) : NW'(0);
      mdst[j] = j < 3 ? NW'(2) : NW'(0);
    end
    fm2[0] = {3{16'h7FFF}};
    run2("sat pos", 3, 16, {3{17'h0FFFF}}, 1'b1);
    fm2[0] = {3{16'h8000}};
    run2("sat neg", 3, 16, {3{17'h10000}}, 1'b1);
    run2("sat clear", 0, 7, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
